// File: rtl/regfile_bypass_scoreboard_pkg.sv
// Shared register-file constants and the port slicing helper used by the pipeline stages.
`ifndef REGFILE_BYPASS_SCOREBOARD_PKG_SV
`define REGFILE_BYPASS_SCOREBOARD_PKG_SV

// Selects the i-th w-bit field of a flattened multi-port bus.
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package regfile_bypass_scoreboard_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_NUM_READ = 3;
  localparam int PC_IDX      = (1 << RF_ADDR_W) - 1;

  typedef enum logic [1:0] {
    SRC_BANK   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_PC     = 2'd2
  } rd_src_e;

endpackage

`endif

// File: rtl/regfile_read_port.sv
// One combinational read port: PC override, same-cycle writeback bypass and busy gating.
module regfile_read_port
  import regfile_bypass_scoreboard_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] r15,
  input  logic [DATA_W-1:0] bank_data,
  input  logic              pend,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PC_A = {ADDR_W{1'b1}};

  rd_src_e src_s;
  logic    hit_wb_s;

  // Choose the data source in priority order PC > bypass > bank.
  always_comb begin
    hit_wb_s = we3 && (a3 == a);
    if (a == PC_A) begin
      src_s = SRC_PC;
    end else if (hit_wb_s) begin
      src_s = SRC_BYPASS;
    end else begin
      src_s = SRC_BANK;
    end
  end

  // Drive read data and busy; a completing writeback hides the pending bit.
  always_comb begin
    rd   = bank_data;
    busy = 1'b0;
    case (src_s)
      SRC_PC: begin
        rd   = r15;
        busy = 1'b0;
      end
      SRC_BYPASS: begin
        rd   = wd3;
        busy = 1'b0;
      end
      SRC_BANK: begin
        rd   = bank_data;
        busy = pend;
      end
      default: begin
        rd   = bank_data;
        busy = pend;
      end
    endcase
  end

endmodule

// File: rtl/regfile_bypass_scoreboard.sv
// Register bank with PC override, write bypass and a per-register pending scoreboard
// used by decode for RAW hazard stalls.
module regfile_bypass_scoreboard
  import regfile_bypass_scoreboard_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_READ = RF_NUM_READ
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_READ*ADDR_W-1:0] A,
  output logic [NUM_READ*DATA_W-1:0] RD,
  output logic [NUM_READ-1:0]        BUSY,
  input  logic [DATA_W-1:0]          R15,
  input  logic                       WE3,
  input  logic [ADDR_W-1:0]          A3,
  input  logic [DATA_W-1:0]          WD3,
  input  logic                       ISSUE_EN,
  input  logic [ADDR_W-1:0]          ISSUE_A,
  input  logic                       FLUSH,
  output logic                       PEND_ANY
);

  localparam int                NREG = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] PC_A = {ADDR_W{1'b1}};

  logic [DATA_W-1:0] bank_r [0:NREG-1];
  logic [NREG-1:0]   pend_r;
  logic [NREG-1:0]   pend_nxt_s;
  logic              wb_ok_s;
  logic              issue_ok_s;

  logic [DATA_W-1:0] port_bank_s [0:NUM_READ-1];
  logic [NUM_READ-1:0] port_pend_s;

  assign wb_ok_s    = WE3 && (A3 != PC_A);
  assign issue_ok_s = ISSUE_EN && (ISSUE_A != PC_A);
  assign PEND_ANY   = |pend_r;

  // Bank write; reset discards any writeback in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < NREG; k++) begin
        bank_r[k] <= '0;
      end
    end else if (wb_ok_s) begin
      bank_r[A3] <= WD3;
    end
  end

  // Next scoreboard state: writeback clears first so a same-index issue wins.
  always_comb begin
    pend_nxt_s = pend_r;
    if (wb_ok_s) begin
      pend_nxt_s[A3] = 1'b0;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    if (issue_ok_s) begin
      pend_nxt_s[ISSUE_A] = 1'b1;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
  end

  // Scoreboard register; flush drops every outstanding write including a new issue.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_r <= '0;
    end else if (FLUSH) begin
      pend_r <= '0;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Per-port bank and pending lookup; the PC index has no storage behind it.
  always_comb begin
    for (int p = 0; p < NUM_READ; p++) begin
      if (`RF_SLICE(A, p, ADDR_W) == PC_A) begin
        port_bank_s[p] = '0;
        port_pend_s[p] = 1'b0;
      end else begin
        port_bank_s[p] = bank_r[`RF_SLICE(A, p, ADDR_W)];
        port_pend_s[p] = pend_r[`RF_SLICE(A, p, ADDR_W)];
      end
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    regfile_read_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_port (
      .a        (`RF_SLICE(A, i, ADDR_W)),
      .r15      (R15),
      .bank_data(port_bank_s[i]),
      .pend     (port_pend_s[i]),
      .we3      (WE3),
      .a3       (A3),
      .wd3      (WD3),
      .rd       (`RF_SLICE(RD, i, DATA_W)),
      .busy     (BUSY[i])
    );
  end

endmodule
